// File: rtl/cpu_test_pkg.sv
// Shared state encoding and constants for the CPU test sequencer.
package cpu_test_pkg;

  localparam int unsigned REG_SEL_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RST   = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_e;

  // States in which a test is in flight.
  function automatic logic is_busy(input state_e s);
    return (s == RST) || (s == RUN) || (s == CHECK);
  endfunction

endpackage

// File: rtl/cpu_test_monitor_if.sv
// Bundle between the test monitor and the CPU / expectation source it supervises.
interface cpu_test_monitor_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned NUM_CHECKS = 4,
  parameter int unsigned CNT_W      = 32
);
  import cpu_test_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_CHECKS) + 1;

  logic                            start;
  logic [ADDR_W-1:0]               pc;
  logic [WIDTH-1:0]                reg_data;
  logic [REG_SEL_W*NUM_CHECKS-1:0] exp_addr;
  logic [WIDTH*NUM_CHECKS-1:0]     exp_val;

  logic                            cpu_reset;
  logic [REG_SEL_W-1:0]            reg_sel;
  logic                            busy;
  logic                            done;
  logic                            pass;
  logic                            timeout;
  logic [IDX_W-1:0]                fail_index;
  logic [WIDTH-1:0]                fail_actual;
  logic [CNT_W-1:0]                cycle_count;

  modport master (
    input  start, pc, reg_data, exp_addr, exp_val,
    output cpu_reset, reg_sel, busy, done, pass, timeout,
           fail_index, fail_actual, cycle_count
  );

  modport slave (
    output start, pc, reg_data, exp_addr, exp_val,
    input  cpu_reset, reg_sel, busy, done, pass, timeout,
           fail_index, fail_actual, cycle_count
  );

endinterface

// File: rtl/halt_detector.sv
// Flags a halted CPU once the PC has held one value for STABLE_CYCLES consecutive cycles.
module halt_detector #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int unsigned STB_W = $clog2(STABLE_CYCLES + 1);

  logic [ADDR_W-1:0] prev_pc_q, prev_pc_d;
  logic [STB_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic              primed_q, primed_d;
  logic              halted_q, halted_d;

  // First enabled cycle only samples the PC; afterwards count repeats.
  always_comb begin
    prev_pc_d    = prev_pc_q;
    stable_cnt_d = stable_cnt_q;
    primed_d     = primed_q;
    if (clear) begin
      prev_pc_d    = '0;
      stable_cnt_d = '0;
      primed_d     = 1'b0;
    end else if (enable) begin
      if (!primed_q) begin
        prev_pc_d    = pc;
        stable_cnt_d = '0;
        primed_d     = 1'b1;
      end else if (pc == prev_pc_q) begin
        if (stable_cnt_q != STB_W'(STABLE_CYCLES)) begin
          stable_cnt_d = stable_cnt_q + STB_W'(1);
        end
      end else begin
        prev_pc_d    = pc;
        stable_cnt_d = '0;
      end
    end
    halted_d = (stable_cnt_d == STB_W'(STABLE_CYCLES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc_q    <= '0;
      stable_cnt_q <= '0;
      primed_q     <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      prev_pc_q    <= prev_pc_d;
      stable_cnt_q <= stable_cnt_d;
      primed_q     <= primed_d;
      halted_q     <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule

// File: rtl/cpu_test_monitor.sv
// Test sequencer: resets the CPU, runs it until halt or timeout, then checks
// a list of architectural registers through the debug read port.
module cpu_test_monitor
  import cpu_test_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned NUM_CHECKS    = 4,
  parameter int unsigned RESET_CYCLES  = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 50000,
  parameter int unsigned CNT_W         = 32
) (
  input logic                clk,
  input logic                reset,
  cpu_test_monitor_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_CHECKS) + 1;
  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);

  state_e               state_q, state_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 cpu_reset_q, cpu_reset_d;
  logic [REG_SEL_W-1:0] reg_sel_q, reg_sel_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [IDX_W-1:0]     fail_index_q, fail_index_d;
  logic [WIDTH-1:0]     fail_actual_q, fail_actual_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;

  logic                 halted;
  logic                 last_check;
  logic [IDX_W-1:0]     next_idx;
  logic [WIDTH-1:0]     cur_exp;
  logic [REG_SEL_W-1:0] first_addr;
  logic [REG_SEL_W-1:0] next_addr;
  logic [CNT_W-1:0]     cnt_next;

  halt_detector #(
    .ADDR_W        (ADDR_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_halt (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != RUN),
    .enable (state_q == RUN),
    .pc     (bus.pc),
    .halted (halted)
  );

  // reg_sel is registered, so it is always set up one cycle ahead of its compare.
  assign last_check = (idx_q == IDX_W'(NUM_CHECKS - 1));
  assign next_idx   = last_check ? idx_q : idx_q + IDX_W'(1);
  assign cur_exp    = bus.exp_val[WIDTH*int'(idx_q) +: WIDTH];
  assign first_addr = bus.exp_addr[REG_SEL_W-1:0];
  assign next_addr  = bus.exp_addr[REG_SEL_W*int'(next_idx) +: REG_SEL_W];
  assign cnt_next   = (cycle_count_q == CNT_W'(TIMEOUT)) ? cycle_count_q
                                                         : cycle_count_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    idx_d         = idx_q;
    cpu_reset_d   = cpu_reset_q;
    reg_sel_d     = reg_sel_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_index_d  = fail_index_q;
    fail_actual_d = fail_actual_q;
    cycle_count_d = cycle_count_q;

    unique case (state_q)
      IDLE, DONE: begin
        cpu_reset_d = (state_q == IDLE);
        if (bus.start) begin
          state_d       = RST;
          cpu_reset_d   = 1'b1;
          rst_cnt_d     = '0;
          idx_d         = '0;
          reg_sel_d     = '0;
          pass_d        = 1'b0;
          timeout_d     = 1'b0;
          fail_index_d  = '0;
          fail_actual_d = '0;
          cycle_count_d = '0;
        end
      end
      RST: begin
        cpu_reset_d = 1'b1;
        if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      RUN: begin
        cpu_reset_d   = 1'b0;
        cycle_count_d = cnt_next;
        // Halt takes priority over a timeout landing in the same cycle.
        if (halted) begin
          state_d   = CHECK;
          idx_d     = '0;
          reg_sel_d = first_addr;
        end else if (cnt_next == CNT_W'(TIMEOUT)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      CHECK: begin
        cpu_reset_d = 1'b0;
        if (bus.reg_data != cur_exp) begin
          state_d       = DONE;
          pass_d        = 1'b0;
          fail_index_d  = idx_q;
          fail_actual_d = bus.reg_data;
        end else if (last_check) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          idx_d     = next_idx;
          reg_sel_d = next_addr;
        end
      end
      default: begin
        state_d     = IDLE;
        cpu_reset_d = 1'b1;
      end
    endcase

    busy_d = is_busy(state_d);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rst_cnt_q     <= '0;
      idx_q         <= '0;
      cpu_reset_q   <= 1'b1;
      reg_sel_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_index_q  <= '0;
      fail_actual_q <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      idx_q         <= idx_d;
      cpu_reset_q   <= cpu_reset_d;
      reg_sel_q     <= reg_sel_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_index_q  <= fail_index_d;
      fail_actual_q <= fail_actual_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.reg_sel     = reg_sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;
  assign bus.timeout     = timeout_q;
  assign bus.fail_index  = fail_index_q;
  assign bus.fail_actual = fail_actual_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_test_monitor.md
Name: cpu_test_monitor

Overview:
Parametrised, synthesizable test sequencer and result checker for the single-cycle CPU. It replaces the fixed-delay, single-register bench check with an FSM that:
- drives the CPU reset pulse;
- counts execution cycles and detects program halt (PC stuck on a jump-to-self);
- compares up to NUM_CHECKS architectural registers against expected values through a debug read port;
- reports pass, fail or timeout with diagnostics.

It sits beside cpu_all in benches and FPGA self-test wrappers.

Parameters:
WIDTH, 32, register data width
ADDR_W, 32, PC width
NUM_CHECKS, 4, number of register compares (1..32)
RESET_CYCLES, 2, cycles cpu_reset is held high after start
STABLE_CYCLES, 4, consecutive unchanged-PC cycles that constitute halt
TIMEOUT, 50000, maximum RUN cycles before timeout
CNT_W, 32, cycle counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset of the monitor
start  in  1  one-cycle request to run a test
pc  in  ADDR_W  CPU program counter
reg_data  in  WIDTH  CPU register debug read data, combinational from reg_sel
exp_addr  in  5*NUM_CHECKS  flattened register numbers; entry i is bits [5i+4:5i]
exp_val  in  WIDTH*NUM_CHECKS  flattened expected values; entry i is bits [WIDTH*i +: WIDTH]
cpu_reset  out  1  active-high reset to the CPU
reg_sel  out  5  register number driven to the debug read port
busy  out  1  high in RST, RUN and CHECK
done  out  1  high in DONE
pass  out  1  valid when done=1
timeout  out  1  valid when done=1
fail_index  out  $clog2(NUM_CHECKS)+1  index of the first mismatching check
fail_actual  out  WIDTH  reg_data captured at the first mismatch
cycle_count  out  CNT_W  RUN cycles elapsed until halt or timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, reg_sel=0, done=0, pass=0, timeout=0.
  - fail_index=0, fail_actual=0, cycle_count=0, internal counters=0.
  - Reset mid-operation aborts the test immediately; cpu_reset reasserts in the same instant.
- States: IDLE, RST, RUN, CHECK, DONE. All outputs are registered.
- IDLE:
  - cpu_reset=1.
  - start=1 goes to RST; diagnostic outputs and cycle_count clear on the same edge.
- RST:
  - cpu_reset=1 for exactly RESET_CYCLES cycles, then RUN.
- RUN:
  - cpu_reset=0; cycle_count increments by 1 every cycle.
  - On the first RUN cycle, prev_pc loads pc and stable_cnt=0.
  - Thereafter: if pc==prev_pc then stable_cnt++, else stable_cnt=0 and prev_pc=pc.
  - stable_cnt reaching STABLE_CYCLES moves to CHECK with check index=0.
  - cycle_count reaching TIMEOUT moves to DONE with timeout=1, pass=0.
  - If halt and timeout occur in the same cycle, halt wins (go to CHECK).
- CHECK:
  - cpu_reset=0, so the CPU stays in its halt loop.
  - One compare per cycle: reg_sel=exp_addr[idx], compared against exp_val[idx] in the same cycle.
  - On mismatch: DONE, pass=0, fail_index=idx, fail_actual=reg_data.
  - If idx==NUM_CHECKS-1 and it matches: DONE, pass=1.
  - Latency from entering CHECK to done is NUM_CHECKS cycles when all checks match.
- DONE:
  - done=1; results and cycle_count held; cpu_reset=0.
  - start=1 restarts the sequence at RST and clears the results.
- start is ignored in RST, RUN and CHECK.
- Register 0 is a legal check target.
- cycle_count saturates at TIMEOUT and never wraps.

Decomposition:
- Shared package cpu_test_pkg holds:
  - the state encoding (IDLE=0, RST=1, RUN=2, CHECK=3, DONE=4);
  - the register-number width constant REG_SEL_W=5.
- One sub-module, halt_detector, owns prev_pc and stable_cnt.
  - Inputs: clk, reset, clear, enable, pc.
  - Output: halted, high when stable_cnt reaches STABLE_CYCLES.

Test Plan:
- Fib program: cpu_all loaded with fib_func.dat, NUM_CHECKS=1, exp_addr=2, exp_val=0x3a, start pulse -> done=1, pass=1, timeout=0, cycle_count>0.
- Mismatch: CPU stub halts at cycle 20 with reg 2=0x3a, reg 8=0x5, reg 9=0x7, reg 10=0x1; expectations are 0x3a, 0x5, 0x8, 0x1 -> pass=0, fail_index=2, fail_actual=0x7, done exactly 3 cycles after CHECK entry.
- Timeout: TIMEOUT=100, stub PC increments every cycle -> done at RUN cycle 100, timeout=1, pass=0, cycle_count=100.
- Timing: RESET_CYCLES=3 -> cpu_reset high for exactly 3 cycles after start, low afterwards. A start pulse during RUN changes nothing.
- Reset mid-RUN: reset=0 at RUN cycle 10 -> asynchronously state=IDLE, cpu_reset=1, cycle_count=0. A new start then produces a normal pass.
- Restart from DONE: start pulse -> results clear, cpu_reset high for RESET_CYCLES, second run yields the identical pass and cycle_count.
